// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave: zero-wait reads and a single-entry posted write buffer with read forwarding.
// Optional simulation trace of transfers and buffer drains when AHB_SRAM_TRACE_EN is defined.
module ahb_sram (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic [31:0] SRAMRDATA,
    output logic [3:0]  SRAMWEN,
    output logic [31:0] SRAMWDATA,
    output logic        SRAMCS0,
    output logic        SRAMCS1,
    output logic        SRAMCS2,
    output logic        SRAMCS3,
    output logic [14:0] SRAMADDR
);

    logic        wrPhase_q, wrPhase_d;
    logic [14:0] wrAddr_q, wrAddr_d;
    logic [1:0]  wrBank_q, wrBank_d;
    logic [3:0]  wrMask_q, wrMask_d;
    logic        rdPhase_q, rdPhase_d;
    logic [14:0] rdAddr_q, rdAddr_d;
    logic [1:0]  rdBank_q, rdBank_d;
    logic        bufValid_q, bufValid_d;
    logic [14:0] bufAddr_q, bufAddr_d;
    logic [1:0]  bufBank_q, bufBank_d;
    logic [3:0]  bufMask_q, bufMask_d;
    logic [31:0] bufData_q, bufData_d;

    logic        readAcc;
    logic        writeAcc;
    logic        bufLoad;
    logic        drain;
    logic        fwdHit;
    logic [3:0]  sizeMask;
    logic [3:0]  sramCs;
    logic        unused;

    assign readAcc  = HSEL & HREADY & HTRANS[1] & ~HWRITE;
    assign writeAcc = HSEL & HREADY & HTRANS[1] & HWRITE;
    assign bufLoad  = wrPhase_q & HREADY;
    assign drain    = bufValid_q & ~readAcc;
    assign fwdHit   = bufValid_q & (bufBank_q == rdBank_q) & (bufAddr_q == rdAddr_q);
    assign unused   = &{1'b0, HADDR[31:19], HTRANS[0]};

    always_comb begin
        case (HSIZE)
            3'b000:  sizeMask = 4'b0001 << HADDR[1:0];
            3'b001:  sizeMask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: sizeMask = 4'b1111;
        endcase
    end

    always_comb begin
        wrPhase_d  = wrPhase_q;
        wrAddr_d   = wrAddr_q;
        wrBank_d   = wrBank_q;
        wrMask_d   = wrMask_q;
        rdPhase_d  = rdPhase_q;
        rdAddr_d   = rdAddr_q;
        rdBank_d   = rdBank_q;
        bufValid_d = bufValid_q;
        bufAddr_d  = bufAddr_q;
        bufBank_d  = bufBank_q;
        bufMask_d  = bufMask_q;
        bufData_d  = bufData_q;
        if (HREADY) begin
            wrPhase_d = writeAcc;
            rdPhase_d = readAcc;
            if (writeAcc) begin
                wrAddr_d = HADDR[16:2];
                wrBank_d = HADDR[18:17];
                wrMask_d = sizeMask;
            end
            if (readAcc) begin
                rdAddr_d = HADDR[16:2];
                rdBank_d = HADDR[18:17];
            end
        end
        // A load on the same edge as a drain replaces the entry just written out.
        if (bufLoad) begin
            bufValid_d = 1'b1;
            bufAddr_d  = wrAddr_q;
            bufBank_d  = wrBank_q;
            bufMask_d  = wrMask_q;
            bufData_d  = HWDATA;
        end else if (drain) begin
            bufValid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wrPhase_q  <= 1'b0;
            wrAddr_q   <= '0;
            wrBank_q   <= '0;
            wrMask_q   <= '0;
            rdPhase_q  <= 1'b0;
            rdAddr_q   <= '0;
            rdBank_q   <= '0;
            bufValid_q <= 1'b0;
            bufAddr_q  <= '0;
            bufBank_q  <= '0;
            bufMask_q  <= '0;
            bufData_q  <= '0;
        end else begin
            wrPhase_q  <= wrPhase_d;
            wrAddr_q   <= wrAddr_d;
            wrBank_q   <= wrBank_d;
            wrMask_q   <= wrMask_d;
            rdPhase_q  <= rdPhase_d;
            rdAddr_q   <= rdAddr_d;
            rdBank_q   <= rdBank_d;
            bufValid_q <= bufValid_d;
            bufAddr_q  <= bufAddr_d;
            bufBank_q  <= bufBank_d;
            bufMask_q  <= bufMask_d;
            bufData_q  <= bufData_d;
        end
    end

    // Outputs are forced idle during reset because the registers only clear at the edge.
    always_comb begin
        HREADYOUT = 1'b1;
        HRDATA    = '0;
        SRAMADDR  = '0;
        SRAMWEN   = '0;
        SRAMWDATA = '0;
        sramCs    = '0;
        if (HRESETn) begin
            HREADYOUT = ~(bufValid_q & wrPhase_q & HSEL & HTRANS[1] & ~HWRITE);
            if (readAcc) begin
                SRAMADDR = HADDR[16:2];
                sramCs   = 4'b0001 << HADDR[18:17];
            end else if (drain) begin
                SRAMADDR  = bufAddr_q;
                sramCs    = 4'b0001 << bufBank_q;
                SRAMWEN   = bufMask_q;
                SRAMWDATA = bufData_q;
            end
            if (rdPhase_q) begin
                for (int n = 0; n < 4; n++) begin
                    HRDATA[8*n +: 8] = (fwdHit & bufMask_q[n]) ? bufData_q[8*n +: 8]
                                                               : SRAMRDATA[8*n +: 8];
                end
            end
        end
    end

    assign SRAMCS0 = sramCs[0];
    assign SRAMCS1 = sramCs[1];
    assign SRAMCS2 = sramCs[2];
    assign SRAMCS3 = sramCs[3];

`ifdef AHB_SRAM_TRACE_EN
    always @(posedge HCLK) begin
        if (HRESETn && (readAcc || writeAcc))
            $display("ahb_sram: %s HADDR=%h HSIZE=%b", HWRITE ? "WRITE" : "READ", HADDR, HSIZE);
        if (HRESETn && drain)
            $display("ahb_sram: drain bank=%0d addr=%h mask=%b data=%h",
                     bufBank_q, bufAddr_q, bufMask_q, bufData_q);
    end
`endif

endmodule

// File: tb/tb_ahb_sram.sv
// Directed self-checking bench for ahb_sram with a behavioural four-bank SRAM model.
// HREADY is looped back from HREADYOUT, with an override used to test a stalled bus.
module tb_ahb_sram;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [2:0] SZ_B   = 3'b000;
    localparam logic [2:0] SZ_H   = 3'b001;
    localparam logic [2:0] SZ_W   = 3'b010;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HREADY;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [31:0] SRAMRDATA;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic        SRAMCS0, SRAMCS1, SRAMCS2, SRAMCS3;
    logic [14:0] SRAMADDR;

    logic        hreadyForce;
    logic [3:0]  csVec;
    logic [31:0] mem [0:1023];
    logic [9:0]  memIdx;
    int          writeCount;
    int          assertCount;
    int          failCount;

    ahb_sram dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HREADY(HREADY),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
        .SRAMCS0(SRAMCS0), .SRAMCS1(SRAMCS1), .SRAMCS2(SRAMCS2), .SRAMCS3(SRAMCS3),
        .SRAMADDR(SRAMADDR)
    );

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT & hreadyForce;
    assign csVec  = {SRAMCS3, SRAMCS2, SRAMCS1, SRAMCS0};

    // SRAM model: byte-masked writes, registered reads, low 8 word-address bits per bank.
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (csVec[b]) begin
                memIdx = {b[1:0], SRAMADDR[7:0]};
                if (SRAMWEN != 4'b0000) begin
                    for (int n = 0; n < 4; n++)
                        if (SRAMWEN[n]) mem[memIdx][8*n +: 8] = SRAMWDATA[8*n +: 8];
                    writeCount++;
                end else begin
                    SRAMRDATA <= mem[memIdx];
                end
            end
        end
    end

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = write;
        HADDR  = addr;
        HSIZE  = size;
        HWDATA = wdata;
    endtask

    task automatic nextCycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h40, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b1) begin failCount++; $display("[TB] FAIL reset_hreadyout actual=%b required=1", HREADYOUT); end
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_cs actual=%b required=0000", csVec); end
        assertCount++; if (SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_wen actual=%b required=0000", SRAMWEN); end
        assertCount++; if (SRAMADDR !== 15'h0) begin failCount++; $display("[TB] FAIL reset_addr actual=%h required=0000", SRAMADDR); end
        assertCount++; if (SRAMWDATA !== 32'h0) begin failCount++; $display("[TB] FAIL reset_wdata actual=%h required=00000000", SRAMWDATA); end
        assertCount++; if (HRDATA !== 32'h0) begin failCount++; $display("[TB] FAIL reset_hrdata actual=%h required=00000000", HRDATA); end
        nextCycle();
        HRESETn = 1'b1;
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'h0) begin failCount++; $display("[TB] FAIL post_reset_hrdata actual=%h required=00000000", HRDATA); end
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL post_reset_cs actual=%b required=0000", csVec); end
        nextCycle();
    endtask

    task automatic test_word_write();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h10, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL ww_addr_phase_cs actual=%b required=0000", csVec); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'hDEADBEEF);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL ww_data_phase_cs actual=%b required=0000", csVec); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0001) begin failCount++; $display("[TB] FAIL ww_drain_cs actual=%b required=0001", csVec); end
        assertCount++; if (SRAMADDR !== 15'h0004) begin failCount++; $display("[TB] FAIL ww_drain_addr actual=%h required=0004", SRAMADDR); end
        assertCount++; if (SRAMWEN !== 4'b1111) begin failCount++; $display("[TB] FAIL ww_drain_wen actual=%b required=1111", SRAMWEN); end
        assertCount++; if (SRAMWDATA !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL ww_drain_wdata actual=%h required=deadbeef", SRAMWDATA); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000 || SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL ww_idle_quiet actual cs=%b wen=%b required cs=0000 wen=0000", csVec, SRAMWEN); end
        assertCount++; if (mem[4] !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL ww_mem actual=%h required=deadbeef", mem[4]); end
        nextCycle();
    endtask

    task automatic test_byte_write();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h00020003, SZ_B, 32'h0);
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'hA5000000);
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0010) begin failCount++; $display("[TB] FAIL bw_drain_cs actual=%b required=0010", csVec); end
        assertCount++; if (SRAMWEN !== 4'b1000) begin failCount++; $display("[TB] FAIL bw_drain_wen actual=%b required=1000", SRAMWEN); end
        assertCount++; if (SRAMADDR !== 15'h0) begin failCount++; $display("[TB] FAIL bw_drain_addr actual=%h required=0000", SRAMADDR); end
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h00020000, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0010 || SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL bw_read_strobe actual cs=%b wen=%b required cs=0010 wen=0000", csVec, SRAMWEN); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'hA5DE0100) begin failCount++; $display("[TB] FAIL bw_read_data actual=%h required=a5de0100", HRDATA); end
        nextCycle();
    endtask

    task automatic test_forwarding();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h40, SZ_W, 32'h0);
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h40, SZ_W, 32'h11223344);
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b1) begin failCount++; $display("[TB] FAIL fwd_no_wait actual=%b required=1", HREADYOUT); end
        assertCount++; if (csVec !== 4'b0001 || SRAMADDR !== 15'h0010 || SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL fwd_read_strobe actual cs=%b addr=%h wen=%b required cs=0001 addr=0010 wen=0000", csVec, SRAMADDR, SRAMWEN); end
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h41, SZ_B, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'h11223344) begin failCount++; $display("[TB] FAIL fwd_word_data actual=%h required=11223344", HRDATA); end
        assertCount++; if (csVec !== 4'b0001 || SRAMWEN !== 4'b1111) begin failCount++; $display("[TB] FAIL fwd_drain actual cs=%b wen=%b required cs=0001 wen=1111", csVec, SRAMWEN); end
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h40, SZ_W, 32'hFFFF77FF);
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b1) begin failCount++; $display("[TB] FAIL fwd_byte_no_wait actual=%b required=1", HREADYOUT); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'h11227744) begin failCount++; $display("[TB] FAIL fwd_merge_data actual=%h required=11227744", HRDATA); end
        assertCount++; if (SRAMWEN !== 4'b0010 || SRAMWDATA !== 32'hFFFF77FF) begin failCount++; $display("[TB] FAIL fwd_byte_drain actual wen=%b wdata=%h required wen=0010 wdata=ffff77ff", SRAMWEN, SRAMWDATA); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (mem[16] !== 32'h11227744) begin failCount++; $display("[TB] FAIL fwd_mem actual=%h required=11227744", mem[16]); end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h80, SZ_W, 32'h0);
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h84, SZ_W, 32'hAAAA0001);
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first_ready actual=%b required=1", HREADYOUT); end
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h84, SZ_W, 32'hBBBB0002);
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_stall actual=%b required=0", HREADYOUT); end
        assertCount++; if (csVec !== 4'b0001 || SRAMADDR !== 15'h0020 || SRAMWEN !== 4'b1111 || SRAMWDATA !== 32'hAAAA0001) begin failCount++; $display("[TB] FAIL b2b_stall_drain actual cs=%b addr=%h wen=%b wdata=%h required cs=0001 addr=0020 wen=1111 wdata=aaaa0001", csVec, SRAMADDR, SRAMWEN, SRAMWDATA); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (HREADYOUT !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_stall_len actual=%b required=1", HREADYOUT); end
        assertCount++; if (csVec !== 4'b0001 || SRAMADDR !== 15'h0021 || SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL b2b_read_strobe actual cs=%b addr=%h wen=%b required cs=0001 addr=0021 wen=0000", csVec, SRAMADDR, SRAMWEN); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'hBBBB0002) begin failCount++; $display("[TB] FAIL b2b_read_data actual=%h required=bbbb0002", HRDATA); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (mem[32] !== 32'hAAAA0001 || mem[33] !== 32'hBBBB0002) begin failCount++; $display("[TB] FAIL b2b_mem actual=%h,%h required=aaaa0001,bbbb0002", mem[32], mem[33]); end
        nextCycle();
    endtask

    task automatic test_halfword();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h06, SZ_H, 32'h0);
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'hBEEF1234);
        nextCycle();
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h08, SZ_H, 32'h0);
        @(negedge HCLK);
        assertCount++; if (SRAMWEN !== 4'b1100 || SRAMWDATA[31:16] !== 16'hBEEF || SRAMADDR !== 15'h1) begin failCount++; $display("[TB] FAIL hw_upper actual wen=%b wdata=%h addr=%h required wen=1100 wdata[31:16]=beef addr=0001", SRAMWEN, SRAMWDATA, SRAMADDR); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0000CAFE);
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (SRAMWEN !== 4'b0011 || SRAMADDR !== 15'h2) begin failCount++; $display("[TB] FAIL hw_lower actual wen=%b addr=%h required wen=0011 addr=0002", SRAMWEN, SRAMADDR); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (mem[1] !== 32'hBEEF0001 || mem[2] !== 32'hC0DECAFE) begin failCount++; $display("[TB] FAIL hw_mem actual=%h,%h required=beef0001,c0decafe", mem[1], mem[2]); end
        nextCycle();
    endtask

    task automatic test_reset_discard();
        int snapCount;
        applyStimulus(1'b1, NONSEQ, 1'b1, 32'h100, SZ_W, 32'h0);
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h12345678);
        nextCycle();
        snapCount = writeCount;
        HRESETn = 1'b0;
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000 || SRAMWEN !== 4'b0000 || SRAMADDR !== 15'h0 || SRAMWDATA !== 32'h0) begin failCount++; $display("[TB] FAIL rst_sram_outputs actual cs=%b wen=%b addr=%h wdata=%h required all zero", csVec, SRAMWEN, SRAMADDR, SRAMWDATA); end
        assertCount++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'h0) begin failCount++; $display("[TB] FAIL rst_bus_outputs actual ready=%b rdata=%h required ready=1 rdata=00000000", HREADYOUT, HRDATA); end
        nextCycle();
        HRESETn = 1'b1;
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000 || SRAMWEN !== 4'b0000) begin failCount++; $display("[TB] FAIL rst_discard actual cs=%b wen=%b required cs=0000 wen=0000", csVec, SRAMWEN); end
        nextCycle();
        @(negedge HCLK);
        assertCount++; if (writeCount !== snapCount || mem[64] !== 32'hC0DE0040) begin failCount++; $display("[TB] FAIL rst_no_write actual writes=%0d mem=%h required writes=%0d mem=c0de0040", writeCount, mem[64], snapCount); end
        nextCycle();
    endtask

    task automatic test_no_access();
        hreadyForce = 1'b0;
        applyStimulus(1'b1, NONSEQ, 1'b0, 32'h40, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL na_hready_low actual=%b required=0000", csVec); end
        nextCycle();
        hreadyForce = 1'b1;
        applyStimulus(1'b1, BUSY, 1'b0, 32'h40, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000 || HRDATA !== 32'h0) begin failCount++; $display("[TB] FAIL na_busy actual cs=%b rdata=%h required cs=0000 rdata=00000000", csVec, HRDATA); end
        nextCycle();
        applyStimulus(1'b0, NONSEQ, 1'b0, 32'h40, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (csVec !== 4'b0000) begin failCount++; $display("[TB] FAIL na_unselected actual=%b required=0000", csVec); end
        nextCycle();
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        @(negedge HCLK);
        assertCount++; if (HRDATA !== 32'h0) begin failCount++; $display("[TB] FAIL na_no_data_phase actual=%h required=00000000", HRDATA); end
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        writeCount  = 0;
        SRAMRDATA   = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
        hreadyForce = 1'b1;
        HRESETn     = 1'b0;
        applyStimulus(1'b0, IDLE, 1'b0, 32'h0, SZ_W, 32'h0);
        nextCycle();
        test_reset();
        test_word_write();
        test_byte_write();
        test_forwarding();
        test_back_to_back();
        test_halfword();
        test_reset_discard();
        test_no_access();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_sram.md
AHB_SRAM -- requirements
Module: ahb_sram

Interface
REQ-001 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-002 HRESETn  in  1  reset, synchronous, active-low.
REQ-003 HSEL  in  1  slave select from bus decoder.
REQ-004 HADDR  in  32  byte address; HADDR[18:17] selects bank, HADDR[16:2] is word address, HADDR[1:0] is byte lane.
REQ-005 HREADY  in  1  bus-wide ready (address phase accepted when high).
REQ-006 HWRITE  in  1  1=write, 0=read.
REQ-007 HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) means active transfer.
REQ-008 HSIZE  in  3  000 byte, 001 halfword, 010 word; 011-111 treated as word.
REQ-009 HWDATA  in  32  write data, valid in data phase.
REQ-010 HRDATA  out  32  read data, valid in data phase.
REQ-011 HREADYOUT  out  1  slave ready.
REQ-012 SRAMRDATA  in  32  SRAM read data, valid one cycle after the SRAM read strobe.
REQ-013 SRAMWEN  out  4  per-byte write enables, active-high, bit n = HWDATA[8n+7:8n].
REQ-014 SRAMWDATA  out  32  SRAM write data.
REQ-015 SRAMCS0..SRAMCS3  out  1 each  active-high bank chip selects, bank 0..3.
REQ-016 SRAMADDR  out  15  SRAM word address.

Function
REQ-017 Read access = HSEL & HREADY & HTRANS[1] & ~HWRITE; write access = same with HWRITE=1; both little-endian.
REQ-018 On read access: SRAMADDR=HADDR[16:2], SRAMCS[HADDR[18:17]]=1, others 0, SRAMWEN=0, same cycle (combinational); data returned in the next (data) phase, zero wait states.
REQ-019 On write access: register word address, bank, byte mask (byte: lane HADDR[1:0]; halfword: lanes {HADDR[1],0} and {HADDR[1],1}; word: all four), and set data-phase-write flag.
REQ-020 At end of write data phase (flag set, HREADY=1): load single-entry write buffer with address, bank, mask, HWDATA; set buffer valid.
REQ-021 Buffer drain: any cycle with buffer valid and no read access drives SRAMADDR/bank CS from buffer, SRAMWEN=mask, SRAMWDATA=buffer data; buffer clears at that edge unless reloaded the same edge.
REQ-022 Simultaneous drain and load at one edge: old entry written, new entry stored.
REQ-023 No SRAM activity (all CS 0, SRAMWEN 0) when neither read access nor drain.
REQ-024 Hazard stall: buffer valid, write data phase active, and HSEL & HTRANS[1] & ~HWRITE asserted (HREADY not used) -> HREADYOUT=0 for one cycle; that cycle drains buffer; next cycle new write loads and read proceeds. HREADYOUT=1 otherwise.
REQ-025 Read forwarding: in read data phase, if buffer valid and buffer bank/address equal registered read bank/address, HRDATA byte n = buffer byte n where mask[n]=1, else SRAMRDATA byte n.
REQ-026 HRDATA = SRAMRDATA (with forwarding) in read data phase; 0 otherwise.
REQ-027 IDLE/BUSY transfers, HSEL=0, or HREADY=0 start no access and leave buffer unaffected except for drain.

Reset
REQ-028 HRESETn=0 at rising edge clears buffer valid, data-phase flags, registered address/bank/mask to 0.
REQ-029 While in reset: HREADYOUT=1, HRDATA=0, SRAMWEN=0, all SRAMCS=0, SRAMADDR=0, SRAMWDATA=0; pending buffered write discarded.

Configuration
REQ-030 Macro AHB_SRAM_TRACE_EN defined: simulation-only print on each accepted transfer of direction, HADDR (hex), HSIZE; on each drain, bank, address, mask, data.
REQ-031 AHB_SRAM_TRACE_EN undefined: no trace code; functional behaviour identical.

Verification
REQ-032 Word write 0x00000010=0xDEADBEEF, then IDLE -> next cycle SRAMCS0=1, SRAMADDR=0x0004, SRAMWEN=1111, SRAMWDATA=0xDEADBEEF.
REQ-033 Byte write 0xA5 to 0x00020003 (bank1), idle, read word -> SRAMCS1=1, SRAMWEN=1000; read returns SRAM contents with byte3=0xA5.
REQ-034 Write 0x11223344 to 0x40, immediately read 0x40 -> HRDATA=0x11223344 via forwarding, zero wait states.
REQ-035 Write A, write B back-to-back, read in B's data phase -> HREADYOUT low exactly one cycle, A written in stall cycle, read data correct.
REQ-036 Reset asserted with buffer valid -> no SRAM write after reset, all outputs at reset values.
REQ-037 Halfword write 0xBEEF to 0x06 -> SRAMWEN=1100, SRAMWDATA[31:16]=0xBEEF.
